uart_rx_sampler: RTL
====================

# uart_rx_sampler

Serial receive front end for the single-port UART bridge. Oversamples the asynchronous `rx` pin, frames 8N1 characters (optionally 8E1), and presents each good byte on `rx_data` with a one-cycle `rx_ready` strobe. These outputs connect directly to the bridge's `rx_data` and `rx_ready` inputs, and the bridge writes the byte into memory. Framing and parity faults are flagged separately and are never presented as data.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Legal range is ≥4. H = `CLKS_PER_BIT`/2, rounded down.
- `clk`  in  1: sole clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low. Release is synchronous to `clk`.
- `rx`  in  1: serial line. Idle level is 1. Asynchronous to `clk`.
- `rx_data`  out  8: last good byte, LSB received first.
- `rx_ready`  out  1: one-cycle strobe. When high, `rx_data` holds a new byte.
- `frame_err`  out  1: one-cycle strobe. The stop bit was sampled as 0.
- `parity_err`  out  1: one-cycle strobe. Parity mismatch. Tied to 0 unless the parity macro (see Configuration) is defined.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, giving `rxs`. The flops reset to 1. All decisions use `rxs` only.
- **IDLE:** `rxs`=0 detected in cycle t0. Clear the bit counter and go to START.
- **START:** at t0+H, sample `rxs`.
  - 1: false start. Return to IDLE, with no strobe.
  - 0: go to DATA.
- **DATA:**
  - Bit i (0..7) is sampled at t0+H+(i+1)·N, where N = `CLKS_PER_BIT`.
  - Each sample is shifted in at the MSB of a shift register, so bit 0 ends at the LSB.
  - The shift register is internal. `rx_data` is not disturbed during reception.
- **PARITY (macro only):** sampled at t0+H+9N. Even parity over the 8 data bits plus the parity bit.
- **STOP:** sampled at t0+H+9N, or t0+H+10N with parity.
  - 1 and parity good: load `rx_data`, pulse `rx_ready`, go to IDLE.
  - 1 and parity bad: pulse `parity_err` only. `rx_data` is unchanged. Go to IDLE.
  - 0: pulse `frame_err` only. `rx_data` is unchanged. Go to BREAK. A parity result is not also reported.
- **BREAK:** stay until `rxs`=1, then go to IDLE. A long low (break condition) therefore yields exactly one `frame_err` and no spurious characters.
- **Back-to-back characters:** a start bit that begins immediately after the stop-bit mid-sample is caught. IDLE is re-entered in the cycle after the stop sample.
- **No handshake:** the consumer must take the byte on the `rx_ready` strobe. `rx_data` holds until the next good byte.

## Timing
- **Reset values:** `rx_data`=8'h00, `rx_ready`=0, `frame_err`=0, `parity_err`=0, `busy`=0. State is IDLE and all counters are 0.
- **Pin-to-detect latency:** 2 cycles from an `rx` edge to the corresponding `rxs` edge.
- **Strobe timing:**
  - `rx_ready`, `frame_err` and `parity_err` are registered and are high in the cycle after the stop sample, i.e. t0+H+9N+1 (8N1).
  - Each is high for exactly 1 cycle.
  - At most one of the three is high in any cycle.
- **Counters:**
  - Cycle counter: ceil(log2(N)) bits. Reloads at every sample point, with no cumulative drift.
  - Bit counter: 4 bits.
- **Reset mid-frame:** asserting `rst_n` low mid-frame aborts immediately and sets all outputs to reset values. After release, the block waits in IDLE. A partial frame still in flight can be seen as a start bit; this is accepted behaviour.
- **`busy` timing:** `busy` rises in the cycle after t0. It falls in the cycle after leaving STOP or BREAK.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - Frame is 8E1, with the PARITY state between DATA and STOP.
  - Stop sample moves to t0+H+10N.
  - `parity_err` is live.
- **Undefined:**
  - Frame is 8N1. No PARITY state is built.
  - `parity_err` is constant 0.
  - Port list is identical in both builds.

## Test plan
- **Good byte:** N=16, reset, then send 0xA5 at 16 clk/bit. Expect `rx_ready` high for 1 cycle at t0+8+144+1 and `rx_data`=0xA5. No error strobes.
- **False start:** a 5-cycle low glitch on `rx`. Expect no strobe, `busy` falls within 10 cycles, and `rx_data` stays 0x00.
- **Framing error and break:** send 0x3C with the stop bit low, then hold `rx` low for 40 bits. Expect exactly one `frame_err`, `rx_data` unchanged, and no `rx_ready`. After `rx` returns high, send 0x01; expect `rx_ready` with 0x01.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with no idle gap. Expect three `rx_ready` strobes exactly 10N apart carrying 0x00, 0xFF, 0x55.
- **Parity (with `UART_RX_PARITY_EN`):** send 0x07 with parity bit 1, then 0x07 with parity bit 0. Expect `rx_ready`/0x07, then `parity_err`, with `rx_data` still 0x07.
- **Reset mid-frame:** drop `rst_n` at bit 4 of 0x81. Expect all outputs at reset values asynchronously. After release and a 12-bit idle, send 0x42; expect `rx_ready`/0x42.

Source files
------------

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_sampler                                               |
// | Function : Oversampling UART receiver front end, 8N1 (8E1 when the       |
// |            UART_RX_PARITY_EN macro is defined).                          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int c_HALF  = CLKS_PER_BIT / 2;
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
    localparam logic [2:0] c_S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd5;
`endif

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxs;
    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_ready;
    logic               r_ferr;
    logic               w_tick;
    logic               w_par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // First sample lands mid start bit; every later one is a full bit apart.
    assign w_tick = (r_state == c_S_START) ? (r_cnt == c_HALF_LAST)
                                           : (r_cnt == c_BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!w_rxs) w_next = c_S_START;
            end
            c_S_START: begin
                if (w_tick) w_next = w_rxs ? c_S_IDLE : c_S_DATA;
            end
            c_S_DATA: begin
                if (w_tick && (r_bitcnt == 4'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = c_S_PARITY;
`else
                    w_next = c_S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_S_PARITY: begin
                if (w_tick) w_next = c_S_STOP;
            end
`endif
            c_S_STOP: begin
                if (w_tick) w_next = w_rxs ? c_S_IDLE : c_S_BREAK;
            end
            c_S_BREAK: begin
                if (w_rxs) w_next = c_S_IDLE;
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != c_S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'h00;
        end else begin
            // Reloading at each sample point keeps the sample grid drift-free.
            if ((r_state == c_S_IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == c_S_IDLE) begin
                r_bitcnt <= 4'd0;
            end else if ((r_state == c_S_DATA) && w_tick) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {w_rxs, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit <= 1'b0;
        end else if ((r_state == c_S_PARITY) && w_tick) begin
            r_par_bit <= w_rxs;
        end
    end

    assign w_par_ok   = ~(^{r_shift, r_par_bit});
    assign parity_err = r_perr;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            // A low stop bit outranks any parity result.
            if ((r_state == c_S_STOP) && w_tick) begin
                if (!w_rxs) begin
                    r_ferr <= 1'b1;
                end else if (w_par_ok) begin
                    r_ready <= 1'b1;
                    r_data  <= r_shift;
                end
`ifdef UART_RX_PARITY_EN
                else begin
                    r_perr <= 1'b1;
                end
`endif
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_ready  = r_ready;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire
